pht_access_scheduler: RTL

- Sequences the single-port pattern history table (PHT) of the branch predictor between two requesters:
  - front-end prediction lookups
  - back-end resolution updates
- Resolutions are buffered in a small FIFO and drained into the PHT when the lookup path is idle.
- A starvation guard and a full-FIFO drain mode bound update latency.
- Sits between the fetch/resolve logic and the PHT/BHR pair; also issues the BHR shift strobe when an update commits.

---
 rtl/pht_access_scheduler.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/pht_access_scheduler.sv
// Arbitrates the single-port PHT between front-end lookups and buffered resolution updates.
// Optional SCHED_STATS_EN adds a saturating lookup-stall counter output.
module pht_access_scheduler #(
  parameter int K      = 4,
  parameter int DEPTH  = 4,
  parameter int STARVE = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         pred_req,
  input  logic [K-1:0]                 pred_index,
  output logic                         pred_ack,
  input  logic                         res_valid,
  input  logic [K-1:0]                 res_index,
  input  logic                         res_outcome,
  output logic                         res_ready,
  output logic                         pht_en,
  output logic                         pht_we,
  output logic [K-1:0]                 pht_index,
  output logic                         pht_outcome,
  output logic                         bhr_shift,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
`ifdef SCHED_STATS_EN
  output logic [15:0]                  lookup_stall_cnt,
`endif
  output logic                         dbg_state
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE + 1);

  localparam logic [0:0] ST_NORMAL = 1'b0;
  localparam logic [0:0] ST_DRAIN  = 1'b1;

  // Handshakes: a resolution transfers on res_valid & res_ready; a lookup is
  // taken on pred_req & pred_ack, with pred_req held until acked.

  logic [K:0]    fifo_mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [0:0]    state_q, state_d;
  logic          pht_en_q, pht_we_q, pht_outcome_q, bhr_shift_q;
  logic [K-1:0]  pht_index_q;

  logic          fifo_empty, fifo_full, push, lookup_gnt, update_gnt;
  logic [K:0]    head;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(DEPTH));
  assign res_ready  = !fifo_full;
  assign push       = res_valid && !fifo_full;
  assign head       = fifo_mem_q[rd_ptr_q];

  always_comb begin
    lookup_gnt = 1'b0;
    update_gnt = 1'b0;
    if (state_q == ST_NORMAL) begin
      lookup_gnt = pred_req;
      update_gnt = !pred_req && !fifo_empty;
    end else begin
      update_gnt = !fifo_empty;
    end
  end

  assign pred_ack = lookup_gnt;

  always_comb begin
    wr_ptr_d = push       ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = update_gnt ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !update_gnt) begin
      count_d = count_q + CW'(1);
    end else if (!push && update_gnt) begin
      count_d = count_q - CW'(1);
    end
  end

  // Wait counter only advances while a queued update is being passed over.
  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || update_gnt) begin
      starve_d = '0;
    end else if (state_q == ST_NORMAL && starve_q != SW'(STARVE)) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_NORMAL: if (starve_q == SW'(STARVE) || fifo_full) state_d = ST_DRAIN;
      ST_DRAIN:  if (count_q == CW'(1) && update_gnt && !push) state_d = ST_NORMAL;
      default:   state_d = ST_NORMAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= {res_index, res_outcome};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      starve_q      <= '0;
      state_q       <= ST_NORMAL;
      pht_en_q      <= 1'b0;
      pht_we_q      <= 1'b0;
      pht_index_q   <= '0;
      pht_outcome_q <= 1'b0;
      bhr_shift_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      starve_q    <= starve_d;
      state_q     <= state_d;
      pht_en_q    <= lookup_gnt || update_gnt;
      bhr_shift_q <= update_gnt;
      if (lookup_gnt) begin
        pht_we_q      <= 1'b0;
        pht_index_q   <= pred_index;
        pht_outcome_q <= 1'b0;
      end else if (update_gnt) begin
        pht_we_q      <= 1'b1;
        pht_index_q   <= head[K:1];
        pht_outcome_q <= head[0];
      end
    end
  end

`ifdef SCHED_STATS_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else if (pred_req && !lookup_gnt && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign lookup_stall_cnt = stall_q;
`endif

  assign pht_en      = pht_en_q;
  assign pht_we      = pht_we_q;
  assign pht_index   = pht_index_q;
  assign pht_outcome = pht_outcome_q;
  assign bhr_shift   = bhr_shift_q;
  assign fifo_count  = count_q;
  assign dbg_state   = state_q;

endmodule
